// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI configuration register bank with auto-increment burst access
//
// Sits behind the SPI address/data decoder. A header byte (is_write, addr)
// opens a burst; each following byte_done either commits wdata to the
// register at the running pointer (WRITE) or reloads the read shift register
// from the next register (READ). Read data leaves MSB-first on poci.
//
// Optional build macro: SPI_REG_SHADOW_EN
//   When defined, burst writes land in a shadow array and are copied to the
//   live registers in a single cycle once cs is sampled low, so regs_flat
//   only ever changes between transactions. Reads always see live values.
//
// Ports:
//   spi_clk    in   SPI clock, all state moves on its rising edge
//   rst        in   asynchronous active-high reset
//   cs         in   chip select, active high; low returns to HEADER
//   byte_done  in   one-cycle pulse on the edge completing a byte
//   is_write   in   header direction bit, sampled with byte_done in HEADER
//   addr       in   header base address, sampled with byte_done in HEADER
//   wdata      in   write data byte, sampled with byte_done in WRITE
//   poci       out  serial read data (MSB of the read shift register)
//   regs_flat  out  all register values, reg i at bits [8i+7:8i]
//   wr_strobe  out  one-cycle pulse per register update
//   wr_addr    out  address of the last committed write

module spi_reg_bank #(
    parameter int         NUM_REGS  = 32,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  spi_clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  byte_done,
    input  logic                  is_write,
    input  logic [6:0]            addr,
    input  logic [7:0]            wdata,
    output logic                  poci,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr
);

    // Index width of the implemented array; pointer bits above it only
    // matter for the range check.
    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [6:0]  ptr;
    logic [7:0]  shreg;
    logic [7:0]  regs [NUM_REGS];

    logic [6:0]  ptr_inc;
    logic [7:0]  hdr_rdata;
    logic [7:0]  next_rdata;
    logic        commit;

    function automatic logic in_range(input logic [6:0] a);
        return ({1'b0, a} < NUM_REGS_W);
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            state <= HEADER;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!cs) begin
            state_next = HEADER;
        end else begin
            case (state)
                HEADER:  if (byte_done) state_next = is_write ? WRITE : READ;
                WRITE:   state_next = WRITE;
                READ:    state_next = READ;
                default: state_next = HEADER;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pointer and read data selection
    // ------------------------------------------------------------------
    // 7-bit add wraps 127 -> 0 naturally.
    assign ptr_inc = ptr + 7'd1;

    always_comb begin
        hdr_rdata  = 8'h00;
        next_rdata = 8'h00;
        if (in_range(addr)) begin
            hdr_rdata = regs[addr[AW-1:0]];
        end
        if (in_range(ptr_inc)) begin
            next_rdata = regs[ptr_inc[AW-1:0]];
        end
    end

    // cs low suppresses a coincident byte, so it gates the commit as well.
    assign commit = cs && byte_done && (state == WRITE) && in_range(ptr);

    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            ptr   <= 7'd0;
            shreg <= 8'h00;
        end else if (!cs) begin
            ptr   <= 7'd0;
            shreg <= 8'h00;
        end else begin
            case (state)
                HEADER: begin
                    if (byte_done) begin
                        ptr <= addr;
                        if (!is_write) begin
                            shreg <= hdr_rdata;
                        end
                    end
                end
                WRITE: begin
                    if (byte_done) begin
                        ptr <= ptr_inc;
                    end
                end
                READ: begin
                    if (byte_done) begin
                        ptr   <= ptr_inc;
                        shreg <= next_rdata;
                    end else begin
                        shreg <= {shreg[6:0], 1'b0};
                    end
                end
                default: begin
                    ptr   <= 7'd0;
                    shreg <= 8'h00;
                end
            endcase
        end
    end

    assign poci = shreg[7];

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
`ifdef SPI_REG_SHADOW_EN
    logic [7:0] shadow [NUM_REGS];
    logic       cs_q;
    logic       dirty;
    logic [6:0] last_addr;

    // Shadow and live only diverge through burst writes, and the copy on cs
    // falling re-aligns them, so the shadow never needs a reverse sync.
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]   <= RESET_VAL;
                shadow[i] <= RESET_VAL;
            end
            cs_q      <= 1'b0;
            dirty     <= 1'b0;
            last_addr <= 7'd0;
            wr_strobe <= 1'b0;
            wr_addr   <= 7'd0;
        end else begin
            cs_q      <= cs;
            wr_strobe <= 1'b0;
            if (commit) begin
                shadow[ptr[AW-1:0]] <= wdata;
                dirty               <= 1'b1;
                last_addr           <= ptr;
            end
            if (!cs && cs_q) begin
                if (dirty) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        regs[i] <= shadow[i];
                    end
                    wr_strobe <= 1'b1;
                    wr_addr   <= last_addr;
                end
                dirty <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            wr_strobe <= 1'b0;
            wr_addr   <= 7'd0;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                regs[ptr[AW-1:0]] <= wdata;
                wr_addr           <= ptr;
            end
        end
    end
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[i*8 +: 8] = regs[i];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - scoreboard bench for spi_reg_bank (32- and 128-register builds)

module tb_spi_reg_bank;

    logic         spi_clk = 1'b0;
    logic         rst;
    logic         cs;
    logic         byte_done;
    logic         is_write;
    logic [6:0]   addr;
    logic [7:0]   wdata;

    logic         poci_a;
    logic [255:0] regs_a;
    logic         wr_strobe_a;
    logic [6:0]   wr_addr_a;

    logic         poci_b;
    logic [1023:0] regs_b;
    logic         wr_strobe_b;
    logic [6:0]   wr_addr_b;

    int checks = 0;
    int fails  = 0;

    logic [6:0] qa_addr [$];
    logic [7:0] qa_data [$];
    logic [6:0] qb_addr [$];
    logic [7:0] qb_data [$];
    logic [7:0] rq [$];

    logic       rd_en = 1'b0;
    logic [7:0] rbits = 8'h00;
    int         rcnt  = 0;

    spi_reg_bank #(.NUM_REGS(32), .RESET_VAL(8'h00)) dut_a (
        .spi_clk   (spi_clk),
        .rst       (rst),
        .cs        (cs),
        .byte_done (byte_done),
        .is_write  (is_write),
        .addr      (addr),
        .wdata     (wdata),
        .poci      (poci_a),
        .regs_flat (regs_a),
        .wr_strobe (wr_strobe_a),
        .wr_addr   (wr_addr_a)
    );

    spi_reg_bank #(.NUM_REGS(128), .RESET_VAL(8'h00)) dut_b (
        .spi_clk   (spi_clk),
        .rst       (rst),
        .cs        (cs),
        .byte_done (byte_done),
        .is_write  (is_write),
        .addr      (addr),
        .wdata     (wdata),
        .poci      (poci_b),
        .regs_flat (regs_b),
        .wr_strobe (wr_strobe_b),
        .wr_addr   (wr_addr_b)
    );

    always #5 spi_clk = ~spi_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitors: every strobe must match the next queued write.
    always @(posedge spi_clk) begin
        #2;
        if (wr_strobe_a === 1'b1) begin
            if (qa_addr.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL strobe_a: unexpected strobe wr_addr %0h, none expected", wr_addr_a);
            end else begin
                automatic int ea = int'(qa_addr.pop_front());
                automatic logic [7:0] ed = qa_data.pop_front();
                chk("wr_addr_a", 32'(wr_addr_a), 32'(ea));
                chk("wr_data_a", 32'(regs_a[ea*8 +: 8]), 32'(ed));
            end
        end
    end

    always @(posedge spi_clk) begin
        #2;
        if (wr_strobe_b === 1'b1) begin
            if (qb_addr.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL strobe_b: unexpected strobe wr_addr %0h, none expected", wr_addr_b);
            end else begin
                automatic int eb = int'(qb_addr.pop_front());
                automatic logic [7:0] edb = qb_data.pop_front();
                chk("wr_addr_b", 32'(wr_addr_b), 32'(eb));
                chk("wr_data_b", 32'(regs_b[eb*8 +: 8]), 32'(edb));
            end
        end
    end

    // Read monitor: gathers 8 poci bits MSB-first while rd_en is high.
    always @(posedge spi_clk) begin
        #2;
        if (rd_en) begin
            rbits = {rbits[6:0], poci_a};
            rcnt++;
            if (rcnt == 8) begin
                rcnt = 0;
                if (rq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL read_byte: got %0h with no expected byte queued", rbits);
                end else begin
                    chk("read_byte", 32'(rbits), 32'(rq.pop_front()));
                end
            end
        end
    end

    task automatic start_txn();
        @(negedge spi_clk);
        cs = 1'b1;
    endtask

    task automatic stop_txn();
        @(negedge spi_clk);
        cs = 1'b0;
        @(negedge spi_clk);
    endtask

    task automatic header(input logic w, input logic [6:0] a);
        @(negedge spi_clk);
        byte_done = 1'b1;
        is_write  = w;
        addr      = a;
        @(negedge spi_clk);
        byte_done = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] d);
        @(negedge spi_clk);
        byte_done = 1'b1;
        wdata     = d;
        @(negedge spi_clk);
        byte_done = 1'b0;
        @(negedge spi_clk);
    endtask

    // Header plus (n-1) further byte_done pulses, each byte 8 cycles apart.
    task automatic rd(input logic [6:0] a, input int n);
        for (int i = 0; i <= n * 8; i++) begin
            @(negedge spi_clk);
            byte_done = ((i % 8) == 0) && (i < n * 8);
            is_write  = 1'b0;
            if (i == 0) addr = a;
            rd_en = (i < n * 8);
        end
        byte_done = 1'b0;
        rd_en     = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs = 1'b0; byte_done = 1'b0; is_write = 1'b0;
        addr = 7'd0; wdata = 8'd0;
        repeat (2) @(negedge spi_clk);

        // Reset state
        chk("reset_regs_a", {31'b0, |regs_a}, 32'd0);
        chk("reset_regs_b", {31'b0, |regs_b}, 32'd0);
        chk("reset_poci", {31'b0, poci_a}, 32'd0);
        chk("reset_strobe", {31'b0, wr_strobe_a}, 32'd0);
        chk("reset_wr_addr", 32'(wr_addr_a), 32'd0);
        rst = 1'b0;
        @(negedge spi_clk);

        // Burst write at 0x05
        qa_addr.push_back(7'd5); qa_data.push_back(8'hA1);
        qa_addr.push_back(7'd6); qa_data.push_back(8'hB2);
        qb_addr.push_back(7'd5); qb_data.push_back(8'hA1);
        qb_addr.push_back(7'd6); qb_data.push_back(8'hB2);
        start_txn();
        header(1'b1, 7'h05);
        wbyte(8'hA1);
        wbyte(8'hB2);
        stop_txn();

        // Burst read at 0x05
        rq.push_back(8'hA1);
        rq.push_back(8'hB2);
        start_txn();
        rd(7'h05, 2);
        stop_txn();

        // Out of range: second byte dropped on the 32-register build
        qa_addr.push_back(7'd31); qa_data.push_back(8'h11);
        qb_addr.push_back(7'd31); qb_data.push_back(8'h11);
        qb_addr.push_back(7'd32); qb_data.push_back(8'h22);
        start_txn();
        header(1'b1, 7'h1F);
        wbyte(8'h11);
        wbyte(8'h22);
        stop_txn();
        rq.push_back(8'h00);
        start_txn();
        rd(7'h20, 1);
        stop_txn();

        // Pointer wrap 127 -> 0
        qa_addr.push_back(7'd0);   qa_data.push_back(8'h44);
        qb_addr.push_back(7'd127); qb_data.push_back(8'h33);
        qb_addr.push_back(7'd0);   qb_data.push_back(8'h44);
        start_txn();
        header(1'b1, 7'h7F);
        wbyte(8'h33);
        wbyte(8'h44);
        stop_txn();
        chk("wrap_reg127_b", 32'(regs_b[127*8 +: 8]), 32'h33);
        chk("wrap_reg0_b", 32'(regs_b[7:0]), 32'h44);
        chk("wrap_reg0_a", 32'(regs_a[7:0]), 32'h44);
        chk("hold_reg31_a", 32'(regs_a[31*8 +: 8]), 32'h11);
        chk("hold_reg5_a", 32'(regs_a[5*8 +: 8]), 32'hA1);

        // cs abort coincident with a data byte
        start_txn();
        header(1'b1, 7'h0A);
        @(negedge spi_clk);
        cs = 1'b0; byte_done = 1'b1; wdata = 8'h55;
        @(negedge spi_clk);
        byte_done = 1'b0;
        @(negedge spi_clk);
        chk("abort_reg10_a", 32'(regs_a[10*8 +: 8]), 32'h00);
        chk("abort_reg10_b", 32'(regs_b[10*8 +: 8]), 32'h00);
        rq.push_back(8'hA1);
        start_txn();
        rd(7'h05, 1);
        stop_txn();

        // Asynchronous reset in the middle of a write burst
        qa_addr.push_back(7'd3); qa_data.push_back(8'h77);
        qb_addr.push_back(7'd3); qb_data.push_back(8'h77);
        start_txn();
        header(1'b1, 7'h03);
        wbyte(8'h77);
        @(negedge spi_clk);
        byte_done = 1'b1; wdata = 8'h99;
        #3 rst = 1'b1;
        #1;
        chk("midrst_regs_a", {31'b0, |regs_a}, 32'd0);
        chk("midrst_regs_b", {31'b0, |regs_b}, 32'd0);
        chk("midrst_poci", {31'b0, poci_a}, 32'd0);
        chk("midrst_strobe", {31'b0, wr_strobe_a}, 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr_a), 32'd0);
        @(negedge spi_clk);
        byte_done = 1'b0;
        @(negedge spi_clk);
        rst = 1'b0;
        // cs still high: the next byte must be taken as a header
        rq.push_back(8'h00);
        rd(7'h03, 1);
        stop_txn();

        repeat (3) @(negedge spi_clk);
        chk("pending_writes_a", 32'(qa_addr.size()), 32'd0);
        chk("pending_writes_b", 32'(qb_addr.size()), 32'd0);
        chk("pending_reads", 32'(rq.size()), 32'd0);
        chk("partial_read_bits", 32'(rcnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
